// File: rtl/parity_reader_pkg.sv
// Shared types and parity helper for the parity reader and its upstream writer bench.
package parity_reader_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Widest {parity, payload} word the helper accepts; narrower words are zero-extended.
  localparam int PAR_MAXW = 64;

  // A word is good when the XOR of all its bits, parity included, is zero.
  // Zero-extension leaves the reduction unchanged.
  function automatic logic parity_ok(input logic [PAR_MAXW-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/parity_reader_fifo.sv
// First-word-fall-through buffer: power-of-two depth, wrapping pointers, 0..DEPTH occupancy.
module parity_fifo #(
  parameter int DWIDTH = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DWIDTH-1:0]          din,
  output logic [DWIDTH-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DWIDTH-1:0] mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         wr_en, rd_en;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/parity_reader.sv
// Parity-checking reader: accepts {parity, payload} words, buffers good payloads,
// counts parity errors and overflow drops, optionally halts on the first error.
module parity_reader
  import parity_reader_pkg::*;
#(
  parameter int DWIDTH      = 10,
  parameter int DEPTH       = 4,
  parameter int CWIDTH      = 4,
  parameter int HALT_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DWIDTH:0]   din,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              full,
  output logic              empty,
  output logic [CWIDTH-1:0] err_cnt,
  output logic [CWIDTH-1:0] ovf_cnt,
  output logic              err_pulse,
  output logic              halted
);

  state_t                 state, next_state;
  logic [PAR_MAXW-1:0]    din_ext;
  logic                   good, accept, push, pop, drop, bad;
  logic [$clog2(DEPTH):0] count;

  assign din_ext = PAR_MAXW'(din);
  assign good    = parity_ok(din_ext);

  // Loads only count while running; HALT swallows them without side effects.
  assign accept  = load && (state == RUN);
  assign pop     = m_valid && m_ready;
  assign push    = accept && good && (!full || pop);
  assign drop    = accept && good && full && !pop;
  assign bad     = accept && !good;

  assign m_valid = !empty;
  assign halted  = (state == HALT);

  parity_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .push   (push),
    .pop    (pop),
    .din    (din[DWIDTH-1:0]),
    .dout   (m_data),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= next_state;
  end

  // Next state: a bad word halts when enabled; only clear returns to RUN.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (bad && (HALT_ON_ERR != 0)) next_state = HALT;
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase
    if (clear) next_state = RUN;
  end

  // Saturating error/overflow counters and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      ovf_cnt   <= '0;
      err_pulse <= 1'b0;
    end else if (clear) begin
      err_cnt   <= '0;
      ovf_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (bad  && (err_cnt != '1)) err_cnt <= err_cnt + CWIDTH'(1);
      if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CWIDTH'(1);
    end
  end

  // Occupancy is kept for future status ports; fold it so it is not left dangling.
  logic unused_count;
  assign unused_count = ^count;

endmodule
